traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter R_TIME, default 20, expected RED dwell minus one, in cycles.
REQ-002 Parameter RY_TIME, default 5, expected RED_YELLOW dwell minus one, in cycles.
REQ-003 Parameter G_TIME, default 25, expected GREEN dwell minus one, in cycles.
REQ-004 Parameter Y_TIME, default 5, expected YELLOW dwell minus one, in cycles.
REQ-005 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port red, input, 1 bit: observed red lamp.
REQ-008 Port yellow, input, 1 bit: observed yellow lamp.
REQ-009 Port green, input, 1 bit: observed green lamp.
REQ-010 Port phase, output, 3 bits: decoded phase (0 OFF, 1 RED, 2 RED_YELLOW, 3 GREEN, 4 YELLOW, 7 ILLEGAL).
REQ-011 Port locked, output, 1 bit: monitor is synchronised to the light sequence.
REQ-012 Port seq_err, output, 1 bit: one-cycle pulse on an illegal phase transition.
REQ-013 Port time_err, output, 1 bit: one-cycle pulse on a wrong phase dwell.
REQ-014 Port illegal_err, output, 1 bit: one-cycle pulse on an illegal lamp combination.
REQ-015 Port err_sticky, output, 1 bit: set by any error pulse; cleared only by reset.
REQ-016 Port cycle_count, output, 8 bits: completed full sequences, saturating at 255.

Function
REQ-017 Decode SHALL map r/y/g as follows: 000 to OFF, 100 to RED, 110 to RED_YELLOW, 001 to GREEN, 010 to YELLOW; every other combination SHALL map to ILLEGAL.
REQ-018 The phase register SHALL hold the decoded value captured at each rising edge; error pulses SHALL be registered and asserted in the cycle after the capturing edge.
REQ-019 The dwell counter SHALL be 6 bits, saturating at 63; it SHALL load 1 on a phase change and increment while the phase is unchanged.
REQ-020 The FSM SHALL have exactly two states, UNSYNC and TRACK; the reset state SHALL be UNSYNC.
REQ-021 UNSYNC: on a captured change into RED from any phase, the FSM SHALL go to TRACK, set locked=1, load dwell=1 and raise no seq_err.
REQ-022 TRACK: the only legal transitions SHALL be RED to RED_YELLOW, RED_YELLOW to GREEN, GREEN to YELLOW, and YELLOW to RED.
REQ-023 TRACK, legal change: dwell SHALL equal the old phase's TIME+1, otherwise time_err SHALL pulse; the FSM SHALL stay in TRACK.
REQ-024 TRACK, dwell reaching TIME+2 with no change: time_err SHALL pulse once, and the later transition SHALL NOT pulse time_err again.
REQ-025 TRACK, change to a non-successor (including OFF): seq_err SHALL pulse, no time check SHALL be made, and the FSM SHALL go to UNSYNC with locked=0.
REQ-026 ILLEGAL captured in any state: illegal_err SHALL pulse once per entry into ILLEGAL, and the FSM SHALL go or stay in UNSYNC with locked=0.
REQ-027 When an illegal transition targets ILLEGAL, illegal_err SHALL pulse and seq_err SHALL NOT pulse.
REQ-028 cycle_count SHALL increment on each legal YELLOW to RED transition in TRACK, regardless of time_err.
REQ-029 Dwell, time and error checks SHALL be active only in TRACK; in UNSYNC, only illegal_err SHALL be generated.

Reset
REQ-030 reset low SHALL immediately force phase=0, locked=0, seq_err=0, time_err=0, illegal_err=0, err_sticky=0, cycle_count=0, dwell=0, state UNSYNC.
REQ-031 Reset released mid-sequence SHALL resynchronise on the next entry into RED; no error other than illegal_err SHALL occur before lock.

Verification
REQ-032 Reset, then OFF 1 cycle, then RED 21, RY 6, GREEN 26, YELLOW 6, RED -> locked=1, no error pulses, cycle_count=1.
REQ-033 Locked, GREEN held 20 cycles then YELLOW -> exactly one time_err pulse, err_sticky=1, locked stays 1.
REQ-034 Locked, RED held 30 cycles -> a single time_err pulse at dwell 22, none at the later transition to RY.
REQ-035 Locked in GREEN, then RED -> seq_err pulse, locked=0; a following full sequence re-locks with no further errors.
REQ-036 r/y/g=101 for 3 cycles -> phase=7, exactly one illegal_err pulse, locked=0.
REQ-037 Run 260 clean sequences -> cycle_count saturates at 255; reset low mid-RED -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//
// Watches the three lamps of a traffic light and checks that they follow
// RED -> RED_YELLOW -> GREEN -> YELLOW -> RED with the expected dwell in each
// phase. The monitor locks onto the sequence at the first observed entry into
// RED and reports sequence, timing and lamp-combination errors while locked.
//
// Parameters
//   R_TIME, RY_TIME, G_TIME, Y_TIME : expected dwell of each phase minus one
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   red          in   observed red lamp
//   yellow       in   observed yellow lamp
//   green        in   observed green lamp
//   phase        out  decoded phase (0 OFF, 1 RED, 2 RED_YELLOW, 3 GREEN,
//                     4 YELLOW, 7 ILLEGAL), registered
//   locked       out  monitor is synchronised to the light sequence
//   seq_err      out  one-cycle pulse on an illegal phase transition
//   time_err     out  one-cycle pulse on a wrong phase dwell
//   illegal_err  out  one-cycle pulse on entry into an illegal lamp combination
//   err_sticky   out  set by any error pulse, cleared only by reset
//   cycle_count  out  completed full sequences, saturating at 255
module traffic_light_monitor #(
  parameter int R_TIME  = 20,
  parameter int RY_TIME = 5,
  parameter int G_TIME  = 25,
  parameter int Y_TIME  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  output logic [2:0] phase,
  output logic       locked,
  output logic       seq_err,
  output logic       time_err,
  output logic       illegal_err,
  output logic       err_sticky,
  output logic [7:0] cycle_count
);

  localparam logic [2:0] PH_OFF     = 3'd0;
  localparam logic [2:0] PH_RED     = 3'd1;
  localparam logic [2:0] PH_RY      = 3'd2;
  localparam logic [2:0] PH_GREEN   = 3'd3;
  localparam logic [2:0] PH_YELLOW  = 3'd4;
  localparam logic [2:0] PH_ILLEGAL = 3'd7;

  // Dwell value a phase must show at the moment it is left.
  localparam logic [6:0] R_LIM  = 7'(R_TIME + 1);
  localparam logic [6:0] RY_LIM = 7'(RY_TIME + 1);
  localparam logic [6:0] G_LIM  = 7'(G_TIME + 1);
  localparam logic [6:0] Y_LIM  = 7'(Y_TIME + 1);

  localparam logic [5:0] DWELL_MAX = 6'd63;
  localparam logic [7:0] COUNT_MAX = 8'd255;

  typedef enum logic {
    UNSYNC = 1'b0,
    TRACK  = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] phase_reg, phase_dec;
  logic [5:0] dwell_reg, dwell_next;
  logic [7:0] count_reg, count_next;
  logic       seq_reg, seq_next;
  logic       time_reg, time_next;
  logic       ill_reg, ill_next;
  logic       sticky_reg, sticky_next;

  logic       changed;
  logic [2:0] succ_phase;
  logic [6:0] dwell_lim;
  logic [6:0] dwell_ext;

  // Lamp decode, index is {red, yellow, green}.
  always_comb begin
    phase_dec = PH_ILLEGAL;
    case ({red, yellow, green})
      3'b000:  phase_dec = PH_OFF;
      3'b100:  phase_dec = PH_RED;
      3'b110:  phase_dec = PH_RY;
      3'b001:  phase_dec = PH_GREEN;
      3'b010:  phase_dec = PH_YELLOW;
      default: phase_dec = PH_ILLEGAL;
    endcase
  end

  // Successor and exit dwell of the current phase. Phases without a
  // successor map onto themselves so they can never match a real change.
  always_comb begin
    succ_phase = phase_reg;
    dwell_lim  = 7'd0;
    case (phase_reg)
      PH_RED:    begin succ_phase = PH_RY;     dwell_lim = R_LIM;  end
      PH_RY:     begin succ_phase = PH_GREEN;  dwell_lim = RY_LIM; end
      PH_GREEN:  begin succ_phase = PH_YELLOW; dwell_lim = G_LIM;  end
      PH_YELLOW: begin succ_phase = PH_RED;    dwell_lim = Y_LIM;  end
      default:   begin succ_phase = phase_reg; dwell_lim = 7'd0;   end
    endcase
  end

  assign changed   = (phase_dec != phase_reg);
  assign dwell_ext = {1'b0, dwell_reg};

  always_comb begin
    if (changed) begin
      dwell_next = 6'd1;
    end else if (dwell_reg == DWELL_MAX) begin
      dwell_next = DWELL_MAX;
    end else begin
      dwell_next = dwell_reg + 6'd1;
    end
  end

  // Next-state and error decision.
  always_comb begin
    state_next = state_reg;
    seq_next   = 1'b0;
    time_next  = 1'b0;
    ill_next   = 1'b0;
    count_next = count_reg;

    if (phase_dec == PH_ILLEGAL) begin
      // Only the entry into ILLEGAL is reported; a target of ILLEGAL is
      // an illegal-combination error, not a sequence error.
      ill_next   = changed;
      state_next = UNSYNC;
    end else if (state_reg == UNSYNC) begin
      if (changed && (phase_dec == PH_RED)) begin
        state_next = TRACK;
      end
    end else if (!changed) begin
      // Overstay is flagged the cycle dwell passes the exit value.
      if (dwell_ext == dwell_lim) begin
        time_next = 1'b1;
      end
    end else if (phase_dec == succ_phase) begin
      // An overstayed phase was already reported, so only a short dwell
      // is an error at the transition itself.
      if (dwell_ext < dwell_lim) begin
        time_next = 1'b1;
      end
      if ((phase_reg == PH_YELLOW) && (count_reg != COUNT_MAX)) begin
        count_next = count_reg + 8'd1;
      end
    end else begin
      seq_next   = 1'b1;
      state_next = UNSYNC;
    end

    sticky_next = sticky_reg | seq_next | time_next | ill_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= UNSYNC;
      phase_reg  <= PH_OFF;
      dwell_reg  <= 6'd0;
      count_reg  <= 8'd0;
      seq_reg    <= 1'b0;
      time_reg   <= 1'b0;
      ill_reg    <= 1'b0;
      sticky_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_dec;
      dwell_reg  <= dwell_next;
      count_reg  <= count_next;
      seq_reg    <= seq_next;
      time_reg   <= time_next;
      ill_reg    <= ill_next;
      sticky_reg <= sticky_next;
    end
  end

  assign phase       = phase_reg;
  assign locked      = (state_reg == TRACK);
  assign seq_err     = seq_reg;
  assign time_err    = time_reg;
  assign illegal_err = ill_reg;
  assign err_sticky  = sticky_reg;
  assign cycle_count = count_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor: directed scenarios plus randomized
// sequences, every cycle compared against a behavioural model of the lamp
// sequence rules.
module tb_traffic_light_monitor;

  localparam int R_TIME  = 20;
  localparam int RY_TIME = 5;
  localparam int G_TIME  = 25;
  localparam int Y_TIME  = 5;

  localparam logic [2:0] L_OFF = 3'b000;
  localparam logic [2:0] L_R   = 3'b100;
  localparam logic [2:0] L_RY  = 3'b110;
  localparam logic [2:0] L_G   = 3'b001;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_BAD = 3'b101;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       red    = 1'b0;
  logic       yellow = 1'b0;
  logic       green  = 1'b0;
  logic [2:0] phase;
  logic       locked;
  logic       seq_err;
  logic       time_err;
  logic       illegal_err;
  logic       err_sticky;
  logic [7:0] cycle_count;

  traffic_light_monitor #(
    .R_TIME (R_TIME),
    .RY_TIME(RY_TIME),
    .G_TIME (G_TIME),
    .Y_TIME (Y_TIME)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .phase      (phase),
    .locked     (locked),
    .seq_err    (seq_err),
    .time_err   (time_err),
    .illegal_err(illegal_err),
    .err_sticky (err_sticky),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model state: current phase, length of its run so far,
  // lock flag, completed sequences and the expected pulses of this cycle.
  int m_phase, m_run, m_count;
  bit m_locked, m_sticky, e_seq, e_time, e_ill;
  int dec_tab[8];
  int tlim[8];
  int succ[8];

  // Pulses seen on the DUT since the last tally clear.
  int c_seq, c_time, c_ill;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_run    = 0;
    m_count  = 0;
    m_locked = 0;
    m_sticky = 0;
    e_seq    = 0;
    e_time   = 0;
    e_ill    = 0;
  endtask

  task automatic model_step(input logic [2:0] rgb);
    int nw;
    bit chg;
    nw     = dec_tab[rgb];
    chg    = (nw != m_phase);
    e_seq  = 0;
    e_time = 0;
    e_ill  = 0;
    if (nw == 7) begin
      e_ill    = chg;
      m_locked = 0;
    end else if (!m_locked) begin
      if (chg && nw == 1) m_locked = 1;
    end else if (!chg) begin
      if (m_run + 1 == tlim[m_phase] + 2) e_time = 1;
    end else if (nw == succ[m_phase]) begin
      if (m_run < tlim[m_phase] + 1) e_time = 1;
      if (m_phase == 4 && m_count < 255) m_count++;
    end else begin
      e_seq    = 1;
      m_locked = 0;
    end
    m_run    = chg ? 1 : m_run + 1;
    m_phase  = nw;
    m_sticky = m_sticky | e_seq | e_time | e_ill;
  endtask

  task automatic clear_tally();
    c_seq  = 0;
    c_time = 0;
    c_ill  = 0;
  endtask

  // Drive one lamp pattern for one clock, then compare all outputs.
  task automatic step(input logic [2:0] rgb);
    {red, yellow, green} = rgb;
    @(posedge clk);
    model_step(rgb);
    @(negedge clk);
    check("phase",       int'(phase),       m_phase);
    check("locked",      int'(locked),      int'(m_locked));
    check("seq_err",     int'(seq_err),     int'(e_seq));
    check("time_err",    int'(time_err),    int'(e_time));
    check("illegal_err", int'(illegal_err), int'(e_ill));
    check("err_sticky",  int'(err_sticky),  int'(m_sticky));
    check("cycle_count", int'(cycle_count), m_count);
    c_seq  += int'(seq_err);
    c_time += int'(time_err);
    c_ill  += int'(illegal_err);
  endtask

  task automatic run(input logic [2:0] rgb, input int n);
    for (int i = 0; i < n; i++) step(rgb);
  endtask

  task automatic clean_seq();
    run(L_R, R_TIME + 1);
    run(L_RY, RY_TIME + 1);
    run(L_G, G_TIME + 1);
    run(L_Y, Y_TIME + 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"},  int'(phase),       0);
    check({tag, "_locked"}, int'(locked),      0);
    check({tag, "_seq"},    int'(seq_err),     0);
    check({tag, "_time"},   int'(time_err),    0);
    check({tag, "_ill"},    int'(illegal_err), 0);
    check({tag, "_sticky"}, int'(err_sticky),  0);
    check({tag, "_count"},  int'(cycle_count), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] codes[4];
    int         lens[4];
    int         len, r;
    logic [2:0] junk;

    dec_tab = '{0, 3, 4, 7, 1, 7, 2, 7};
    tlim    = '{0, R_TIME, RY_TIME, G_TIME, Y_TIME, 0, 0, 0};
    succ    = '{-1, 2, 3, 4, 1, -1, -1, -1};
    codes   = '{L_R, L_RY, L_G, L_Y};
    lens    = '{R_TIME + 1, RY_TIME + 1, G_TIME + 1, Y_TIME + 1};
    model_reset();
    clear_tally();

    // Reset state
    #1 reset = 1'b0;
    #2 check_all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    $display("reset released, outputs idle");

    // Clean first sequence locks and counts one cycle
    clear_tally();
    run(L_OFF, 1);
    clean_seq();
    run(L_R, 1);
    check("a_locked", int'(locked), 1);
    check("a_count", int'(cycle_count), 1);
    check("a_errs", c_seq + c_time + c_ill, 0);
    check("a_sticky", int'(err_sticky), 0);
    $display("clean sequence: locked=%0d count=%0d", locked, cycle_count);

    // Short GREEN
    run(L_R, R_TIME);
    run(L_RY, RY_TIME + 1);
    clear_tally();
    run(L_G, 20);
    run(L_Y, 1);
    check("b_time_pulses", c_time, 1);
    check("b_sticky", int'(err_sticky), 1);
    check("b_locked", int'(locked), 1);
    run(L_Y, Y_TIME);
    $display("short green: time_err pulses=%0d", c_time);

    // Long RED: a single pulse at dwell 22, none at the exit
    clear_tally();
    run(L_R, R_TIME + 1);
    check("c_no_early", c_time, 0);
    step(L_R);
    check("c_pulse_at_22", int'(time_err), 1);
    run(L_R, 8);
    run(L_RY, 1);
    check("c_time_pulses", c_time, 1);
    run(L_RY, RY_TIME);
    run(L_G, G_TIME + 1);
    run(L_Y, Y_TIME + 1);
    $display("long red: time_err pulses=%0d", c_time);

    // GREEN -> RED breaks the lock, next sequence relocks cleanly
    run(L_R, R_TIME + 1);
    run(L_RY, RY_TIME + 1);
    run(L_G, 10);
    clear_tally();
    step(L_R);
    check("d_seq_pulse", c_seq, 1);
    check("d_no_time", c_time, 0);
    check("d_unlocked", int'(locked), 0);
    clear_tally();
    run(L_R, R_TIME);
    run(L_RY, RY_TIME + 1);
    run(L_G, G_TIME + 1);
    run(L_Y, Y_TIME + 1);
    clean_seq();
    run(L_R, 1);
    check("d_relocked", int'(locked), 1);
    check("d_no_errs", c_seq + c_time + c_ill, 0);
    $display("sequence break and relock: locked=%0d", locked);

    // Illegal lamps held
    clear_tally();
    run(L_BAD, 3);
    check("e_phase", int'(phase), 7);
    check("e_ill_pulses", c_ill, 1);
    check("e_no_seq", c_seq, 0);
    check("e_unlocked", int'(locked), 0);
    $display("illegal lamps: illegal_err pulses=%0d", c_ill);

    // Randomized sequences with occasional dwell errors and junk patterns
    for (int s = 0; s < 40; s++) begin
      for (int p = 0; p < 4; p++) begin
        r   = int'($urandom_range(0, 99));
        len = (r < 10) ? int'($urandom_range(1, 32)) : lens[p];
        if (r >= 94) begin
          junk = 3'($urandom_range(0, 7));
          run(junk, int'($urandom_range(1, 3)));
        end
        run(codes[p], len);
      end
      $display("random sequence %0d: count=%0d locked=%0d", s, cycle_count, locked);
    end

    // Saturation of cycle_count, then asynchronous reset mid-RED
    reset = 1'b0;
    model_reset();
    #1 check_all_zero("rst2");
    @(negedge clk);
    reset = 1'b1;
    run(L_OFF, 1);
    for (int s = 0; s < 260; s++) clean_seq();
    run(L_R, 1);
    check("g_saturated", int'(cycle_count), 255);
    run(L_R, 24);
    check("g_sticky", int'(err_sticky), 1);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all_zero("async");
    @(negedge clk);
    @(negedge clk);
    check_all_zero("held");
    reset = 1'b1;
    $display("saturation and async reset: count was 255, outputs cleared");

    // Reset released mid-sequence resynchronises at next RED
    clear_tally();
    run(L_G, 10);
    run(L_Y, Y_TIME + 1);
    clean_seq();
    run(L_R, 1);
    check("h_locked", int'(locked), 1);
    check("h_no_errs", c_seq + c_time + c_ill, 0);
    check("h_count", int'(cycle_count), 1);
    $display("mid-sequence resync: locked=%0d count=%0d", locked, cycle_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
